// File: rtl/hss_stream_normalizer.sv
// hss_stream_normalizer
//
// AXI-Stream sample conditioner between the PCG sample source and the
// FIR/envelope stage. Each accepted sample goes through one of four modes
// (bypass, saturating abs, fixed-point square, block-adaptive shift) and
// lands in a single output register. A wrapping phase index travels with
// it on the config channel.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   mode                   0 bypass, 1 abs, 2 square, 3 block-normalise
//   s_axis_data_*          input sample stream (tdata/tvalid/tready)
//   m_axis_data_*          processed sample stream
//   m_axis_config_*        phase index (zero-extended to 8 bits)
//   block_shift            left shift currently applied in mode 3
//   sat_count              saturating count of saturated outputs
//
// Handshake: a transfer happens on any rising edge where valid and ready
// are both high. Once valid is high, it and the payload stay stable until
// that transfer. The data and config outputs form one joint transfer
// (pop = out_valid & both readies), so neither channel completes alone.
// s_axis_data_tready is combinational. The register can take a new sample
// whenever it is empty or is being popped in the same cycle, so there is
// no bubble under continuous ready.

module hss_stream_normalizer #(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 24,
  parameter int BLOCK_LEN  = 64,
  parameter int MAX_SHIFT  = 16,
  parameter int NUM_PHASES = 24
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic [7:0]       m_axis_config_tdata,
  output logic             m_axis_config_tvalid,
  input  logic             m_axis_config_tready,
  output logic [5:0]       block_shift,
  output logic [15:0]      sat_count
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [7:0]       PHASE_MAX = 8'(NUM_PHASES);
  localparam logic [5:0]       SHIFT_MAX = 6'(MAX_SHIFT);

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Range limits sign-extended to the double-width working precision.
  localparam logic signed [2*WIDTH-1:0] MAX_EXT = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN_EXT = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0]        MAX_U   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  // Registered state
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_phase;
  logic [7:0]       phase_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] blk_cnt;
  logic [WIDTH-1:0] peak_q;
  logic [5:0]       shift_q;
  logic [15:0]      sat_q;

  // Combinational datapath
  logic                      pop;
  logic                      accept;
  logic [1:0]                eff_mode;
  logic [WIDTH-1:0]          x_abs;
  logic [WIDTH-1:0]          peak_next;
  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]        sq_shifted;
  logic signed [2*WIDTH-1:0] shl;
  logic [WIDTH-1:0]          result;
  logic                      res_sat;
  logic [5:0]                lz_peak;
  logic [5:0]                new_shift;
  logic [7:0]                phase_next;

  // Leading zeros in bits [WIDTH-2:0]. The sign bit is excluded because
  // the argument is always a non-negative magnitude.
  function automatic logic [5:0] lz_fn(input logic [WIDTH-1:0] v);
    logic [5:0] n;
    logic       seen;
    n    = 6'd0;
    seen = 1'b0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (!seen) begin
        if (v[i]) seen = 1'b1;
        else      n    = n + 6'd1;
      end
    end
    return n;
  endfunction

  assign pop    = out_valid & m_axis_data_tready & m_axis_config_tready;
  assign s_axis_data_tready = aresetn & (~out_valid | (m_axis_data_tready & m_axis_config_tready));
  assign accept = s_axis_data_tvalid & s_axis_data_tready;

  always_comb begin
    eff_mode   = (blk_cnt == '0) ? mode : mode_q;
    x_abs      = '0;
    x_ext      = '0;
    prod       = '0;
    sq_shifted = '0;
    shl        = '0;
    result     = '0;
    res_sat    = 1'b0;

    // Saturating magnitude: the most negative value has no positive twin.
    if (s_axis_data_tdata == NEG_MIN)      x_abs = POS_MAX;
    else if (s_axis_data_tdata[WIDTH-1])   x_abs = -s_axis_data_tdata;
    else                                   x_abs = s_axis_data_tdata;

    x_ext = {{WIDTH{s_axis_data_tdata[WIDTH-1]}}, s_axis_data_tdata};
    // Square fits exactly in 2*WIDTH bits: |x|^2 <= 2^(2*WIDTH-2).
    prod       = x_ext * x_ext;
    sq_shifted = prod >> FRAC_BITS;
    shl        = x_ext <<< shift_q;

    case (eff_mode)
      2'd0: result = s_axis_data_tdata;
      2'd1: result = x_abs;
      2'd2: begin
        if (sq_shifted > MAX_U) begin
          result  = POS_MAX;
          res_sat = 1'b1;
        end else begin
          result = sq_shifted[WIDTH-1:0];
        end
      end
      default: begin
        if (shl > MAX_EXT) begin
          result  = POS_MAX;
          res_sat = 1'b1;
        end else if (shl < MIN_EXT) begin
          result  = NEG_MIN;
          res_sat = 1'b1;
        end else begin
          result = shl[WIDTH-1:0];
        end
      end
    endcase

    peak_next  = (x_abs > peak_q) ? x_abs : peak_q;
    lz_peak    = lz_fn(peak_next);
    new_shift  = (lz_peak > SHIFT_MAX) ? SHIFT_MAX : lz_peak;
    phase_next = (phase_q == PHASE_MAX) ? 8'd1 : phase_q + 8'd1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_phase <= '0;
      phase_q   <= '0;
      mode_q    <= '0;
      blk_cnt   <= '0;
      peak_q    <= '0;
      shift_q   <= '0;
      sat_q     <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_phase <= phase_next;
        phase_q   <= phase_next;
        if (blk_cnt == '0) mode_q <= mode;
        // The new shift takes effect from the next accepted sample.
        if (blk_cnt == LAST_CNT) begin
          blk_cnt <= '0;
          peak_q  <= '0;
          shift_q <= new_shift;
        end else begin
          blk_cnt <= blk_cnt + CNT_W'(1);
          peak_q  <= peak_next;
        end
        if (res_sat && (sat_q != 16'hFFFF)) sat_q <= sat_q + 16'd1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_data_tdata    = out_data;
  assign m_axis_data_tvalid   = out_valid;
  assign m_axis_config_tdata  = out_phase;
  assign m_axis_config_tvalid = out_valid;
  assign block_shift          = shift_q;
  assign sat_count            = sat_q;

endmodule

// File: tb/tb_hss_stream_normalizer.sv
// Testbench for hss_stream_normalizer.
// The driver tasks push expected {data, phase} words from a behavioural
// model into exp_q on every accept. A separate monitor pops and compares on
// every joint output transfer.

module tb_hss_stream_normalizer;

  localparam int WIDTH      = 32;
  localparam int FRAC_BITS  = 23;
  localparam int BLOCK_LEN  = 4;
  localparam int MAX_SHIFT  = 16;
  localparam int NUM_PHASES = 24;
  localparam int EXP_W      = WIDTH + 8;
  localparam longint MAXV   = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint MINV   = -(longint'(1) << (WIDTH - 1));

  logic             aclk;
  logic             aresetn;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [7:0]       cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;
  logic [5:0]       block_shift;
  logic [15:0]      sat_count;

  hss_stream_normalizer #(
    .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .BLOCK_LEN(BLOCK_LEN),
    .MAX_SHIFT(MAX_SHIFT), .NUM_PHASES(NUM_PHASES)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .mode(mode),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .m_axis_config_tdata(cfg_tdata), .m_axis_config_tvalid(cfg_tvalid),
    .m_axis_config_tready(cfg_tready),
    .block_shift(block_shift), .sat_count(sat_count)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // ---------------- output ready driver ----------------
  // ready_mode 0: always ready, 1: random, 2: manual values.
  int   ready_mode = 0;
  logic man_data_rdy = 1'b1;
  logic man_cfg_rdy  = 1'b1;

  initial begin
    m_tready   = 1'b1;
    cfg_tready = 1'b1;
  end

  always @(posedge aclk) begin
    #1;
    if (ready_mode == 0) begin
      m_tready   = 1'b1;
      cfg_tready = 1'b1;
    end else if (ready_mode == 1) begin
      m_tready   = ($urandom_range(0, 99) < 70);
      cfg_tready = ($urandom_range(0, 99) < 70);
    end else begin
      m_tready   = man_data_rdy;
      cfg_tready = man_cfg_rdy;
    end
  end

  task automatic set_ready(input int rm, input logic d, input logic c);
    ready_mode   = rm;
    man_data_rdy = d;
    man_cfg_rdy  = c;
    @(posedge aclk);
    #2;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_cnt;
  longint m_peak;
  int     m_shift;
  int     m_mode;
  int     m_phase;
  int     m_sat;

  function automatic void model_reset();
    m_cnt = 0; m_peak = 0; m_shift = 0; m_mode = 0; m_phase = 0; m_sat = 0;
  endfunction

  function automatic void model_accept(input logic [WIDTH-1:0] x, input logic [1:0] md);
    longint xs, ax, r, p;
    int eff, bl, lz;
    bit sat;
    xs  = longint'($signed(x));
    sat = 1'b0;
    if (m_cnt == 0) m_mode = int'(md);
    eff = m_mode;
    ax  = (xs < 0) ? -xs : xs;
    if (ax > MAXV) ax = MAXV;
    case (eff)
      0: r = xs;
      1: r = ax;
      2: begin
        r = (xs * xs) / (longint'(1) << FRAC_BITS);
        if (r > MAXV) begin r = MAXV; sat = 1'b1; end
      end
      default: begin
        r = xs * (longint'(1) << m_shift);
        if (r > MAXV) begin r = MAXV; sat = 1'b1; end
        if (r < MINV) begin r = MINV; sat = 1'b1; end
      end
    endcase
    if (ax > m_peak) m_peak = ax;
    if (m_cnt == BLOCK_LEN - 1) begin
      bl = 0;
      p  = m_peak;
      while (p > 0) begin bl++; p = p / 2; end
      lz = (WIDTH - 1) - bl;
      m_shift = (lz > MAX_SHIFT) ? MAX_SHIFT : lz;
      m_peak  = 0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
    m_phase = (m_phase == NUM_PHASES) ? 1 : m_phase + 1;
    if (sat && m_sat < 65535) m_sat++;
    exp_q.push_back({r[WIDTH-1:0], m_phase[7:0]});
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    logic [EXP_W-1:0] e;
    if (aresetn) begin
      chk("cfg_tvalid_eq_data_tvalid", longint'(cfg_tvalid), longint'(m_tvalid));
      if (m_tvalid && m_tready && cfg_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", longint'(m_tdata), -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data",  longint'(m_tdata),   longint'(e[EXP_W-1:8]));
          chk("out_phase", longint'(cfg_tdata), longint'(e[7:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] x, input logic [1:0] md);
    int t;
    s_tdata  = x;
    mode     = md;
    s_tvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_tready && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    checks++;
    if (!s_tready) begin
      errors++;
      $display("FAIL accept_timeout: got tready=0 expected 1 at %0t", $time);
    end else begin
      model_accept(x, md);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Only the first sample's mode should matter; the rest carry noise.
  task automatic send_block(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                            input logic [1:0] md);
    send(a, md);
    send(b, 2'($urandom_range(0, 3)));
    send(c, 2'($urandom_range(0, 3)));
    send(d, 2'($urandom_range(0, 3)));
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge aclk);
      t++;
    end
    #2;
    chk("drain_remaining", longint'(exp_q.size()), 0);
  endtask

  function automatic logic [WIDTH-1:0] rand_sample();
    case ($urandom_range(0, 4))
      0:       return WIDTH'($urandom);
      1:       return WIDTH'($urandom_range(0, 1023));
      2:       return -WIDTH'($urandom_range(0, 1 << 20));
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom_range(0, 1 << 16)) << $urandom_range(0, 12);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    mode     = 2'd0;
    model_reset();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", longint'(s_tready), 0);
    chk("rst_m_tvalid", longint'(m_tvalid), 0);
    chk("rst_m_tdata",  longint'(m_tdata), 0);
    chk("rst_cfg_tdata", longint'(cfg_tdata), 0);
    chk("rst_block_shift", longint'(block_shift), 0);
    chk("rst_sat_count", longint'(sat_count), 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Directed blocks: bypass, abs, square, then shift setup and normalise.
    send_block(32'hFFFFFF00, 32'h00000010, 32'h00000020, 32'h00000030, 2'd0);
    send_block(32'hFFFFFF00, 32'h80000000, 32'h00000005, 32'h00000000, 2'd1);
    drain(50);
    chk("sat_after_abs", longint'(sat_count), longint'(m_sat));
    send_block(32'h00800000, 32'h01800000, 32'h7FFFFFFF, 32'h00000000, 2'd2);
    drain(50);
    chk("sat_after_square", longint'(sat_count), longint'(m_sat));
    send_block(32'h00010000, 32'h00000100, 32'hFFFFFF00, 32'h00000000, 2'd0);
    chk("shift_peak_10000", longint'(block_shift), longint'(m_shift));
    send_block(32'h00000100, 32'h00100000, 32'hFFFFFFFF, 32'h00000000, 2'd3);
    drain(50);
    chk("sat_after_norm", longint'(sat_count), longint'(m_sat));
    send_block(32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("shift_all_zero", longint'(block_shift), longint'(m_shift));

    // Continuous stream across phase wraps.
    for (int i = 0; i < 50; i++) send(rand_sample(), 2'($urandom_range(0, 3)));
    drain(50);

    // Config channel stalled with data ready high: output must hold.
    set_ready(2, 1'b1, 1'b0);
    send(32'h00001234, 2'd0);
    fork
      send(32'h00005678, 2'd0);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("stall_s_tready", longint'(s_tready), 0);
      chk("stall_m_tvalid", longint'(m_tvalid), 1);
      chk("stall_m_tdata",  longint'(m_tdata),   longint'(exp_q[0][EXP_W-1:8]));
      chk("stall_cfg_tdata", longint'(cfg_tdata), longint'(exp_q[0][7:0]));
    end
    ready_mode = 0;
    wait fork;
    drain(50);

    // Random valid/ready traffic.
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
      send(rand_sample(), 2'($urandom_range(0, 3)));
    end
    set_ready(0, 1'b1, 1'b1);
    drain(200);
    chk("sat_after_random", longint'(sat_count), longint'(m_sat));
    chk("shift_after_random", longint'(block_shift), longint'(m_shift));

    // Reset mid-block while an output is stalled.
    send(32'h00000042, 2'd1);
    drain(50);
    set_ready(2, 1'b0, 1'b0);
    send(32'h00000077, 2'd2);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rst2_s_tready", longint'(s_tready), 0);
    @(posedge aclk);
    #1;
    chk("rst2_m_tvalid", longint'(m_tvalid), 0);
    chk("rst2_cfg_tvalid", longint'(cfg_tvalid), 0);
    chk("rst2_m_tdata", longint'(m_tdata), 0);
    chk("rst2_cfg_tdata", longint'(cfg_tdata), 0);
    chk("rst2_block_shift", longint'(block_shift), 0);
    chk("rst2_sat_count", longint'(sat_count), 0);
    exp_q.delete();
    model_reset();
    aresetn = 1'b1;
    set_ready(0, 1'b1, 1'b1);
    send_block(32'h40000000, 32'hC0000000, 32'h00000003, 32'h00000000, 2'd3);
    drain(50);
    chk("sat_after_reset_block", longint'(sat_count), longint'(m_sat));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
